// File: rtl/button_event_mem.sv
// Purpose: memory-mapped panel-input peripheral: sync, debounce, edge events queued in a small FIFO for CPU polling.
// Latency: input edge to FIFO entry is 2 + DEBOUNCE_CYCLES + 1 clocks; register reads return on q one cycle after the read.
// Backpressure: none toward the inputs; a push into a full FIFO is dropped and sets a sticky overflow flag.
// Optional: define BUTTON_EVENT_MASK_EN to add the per-input event MASK register at offset 5.
module button_event_mem #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int NUM_IN          = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] q,
  input  logic [NUM_IN-1:0]     btn_in,
  output logic                  event_pending
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]     DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_IN-1:0] sync1, sync2, stable, edge_val, pending;
  logic [CW-1:0]     cnt [NUM_IN];
  logic [NUM_IN-1:0] flip, pend_set, push_clr, pending_nxt;
  logic [3:0]        sel_idx;
  logic              sel_edge, push_req;

  logic [4:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [4:0]        count, count_nxt;
  logic              overflow;
  logic              empty, full, do_pop, do_push, ovf_set;

  logic [2:0]        off;
  logic              wr_cyc, pop_req, flush, ovf_clr;
  logic [15:0]       head, level_ext, rd_val;
  logic              unused_bits;

`ifdef BUTTON_EVENT_MASK_EN
  logic [NUM_IN-1:0] mask;
  logic              mask_wr;
  logic [15:0]       mask_ext;
`endif

  assign off     = addr[2:0];
  assign wr_cyc  = en & we;
  assign pop_req = wr_cyc & (off == 3'd3);
  assign flush   = wr_cyc & (off == 3'd4) & data[0];
  assign ovf_clr = wr_cyc & (off == 3'd0) & data[8];
  assign unused_bits = ^{addr[ADDR_WIDTH-1:3], data};

  // An input flips its stable level once it has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    flip = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      flip[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Lowest-index pending input wins the single push slot each cycle
  always_comb begin
    sel_idx  = '0;
    sel_edge = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx  = 4'(i);
        sel_edge = edge_val[i];
      end
    end
    push_req = |pending;
    push_clr = pending & (~pending + NUM_IN'(1));
  end

  // Pending flags: set by debounced flips (unless masked), cleared by arbitration, flush or masking
  always_comb begin
`ifdef BUTTON_EVENT_MASK_EN
    mask_wr     = wr_cyc & (off == 3'd5);
    pend_set    = flip & ~mask;
    pending_nxt = (pending & ~push_clr) | pend_set;
    if (mask_wr) pending_nxt = pending_nxt & ~data[NUM_IN-1:0];
`else
    pend_set    = flip;
    pending_nxt = (pending & ~push_clr) | pend_set;
`endif
    if (flush) pending_nxt = '0;
  end

  // FIFO control: pop only when non-empty; a full FIFO accepts a push only alongside a pop
  always_comb begin
    empty   = (count == 5'd0);
    full    = (count == DEPTH_C);
    do_pop  = pop_req & ~empty;
    do_push = push_req & (~full | do_pop);
    ovf_set = push_req & full & ~do_pop & ~flush;
    count_nxt = count;
    if (flush) count_nxt = 5'd0;
    else if (do_push && !do_pop) count_nxt = count + 5'd1;
    else if (do_pop && !do_push) count_nxt = count - 5'd1;
  end

  // Read-side views and register select
  always_comb begin
    head      = empty ? 16'h0000 : {1'b1, 6'b0, mem[rd_ptr][4], 4'b0, mem[rd_ptr][3:0]};
    level_ext = '0;
    level_ext[NUM_IN-1:0] = stable;
`ifdef BUTTON_EVENT_MASK_EN
    mask_ext  = '0;
    mask_ext[NUM_IN-1:0] = mask;
`endif
    rd_val = '0;
    case (off)
      3'd0: rd_val = {5'b0, full, empty, overflow, 3'b0, count};
      3'd1: rd_val = level_ext;
      3'd2: rd_val = head;
`ifdef BUTTON_EVENT_MASK_EN
      3'd5: rd_val = mask_ext;
`endif
      default: rd_val = '0;
    endcase
  end

  // Two-flop synchroniser and per-input debounce counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      edge_val <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          stable[i]   <= sync2[i];
          edge_val[i] <= sync2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pending event flags
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // FIFO pointers, occupancy, sticky overflow and registered pending indication
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      event_pending <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count         <= count_nxt;
      event_pending <= (count_nxt != 5'd0);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FIFO storage holds only edge and index; the fixed marker bits are added on read
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= {sel_edge, sel_idx};
  end

`ifdef BUTTON_EVENT_MASK_EN
  // Event mask register
  always_ff @(posedge clk) begin
    if (rst)          mask <= '0;
    else if (mask_wr) mask <= data[NUM_IN-1:0];
  end
`endif

  // Registered read data, held when not reading
  always_ff @(posedge clk) begin
    if (rst)            q <= '0;
    else if (en && !we) q <= rd_val;
  end

endmodule

// File: tb/tb_button_event_mem.sv
`timescale 1ns/1ps
module tb_button_event_mem;
  localparam int D      = 4;
  localparam int N      = 8;
  localparam int DEPTH  = 8;
  localparam int SETTLE = D + N + 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   data, addr, q;
  logic          we, en;
  logic [N-1:0]  btn_in;
  logic          event_pending;

  button_event_mem #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .NUM_IN(N),
    .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .en(en),
    .q(q), .btn_in(btn_in), .event_pending(event_pending)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  // reference model: event list, sticky overflow, debounced levels
  logic [15:0] mq[$];
  logic        movf;
  logic [N-1:0] mlvl;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // a read accepted at a posedge presents its data on q after that edge
  always @(posedge clk) rd_seen <= en && !we && !rst;

  // monitor: compare every presented read against the oldest expectation
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read actual=%h expected=none", q);
      end else begin
        logic [15:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, q, e);
      end
    end
  end

  function automatic logic [15:0] m_status();
    int c = mq.size();
    return 16'(c) | (movf ? 16'h0100 : 16'h0) | ((c == 0) ? 16'h0200 : 16'h0)
         | ((c == DEPTH) ? 16'h0400 : 16'h0);
  endfunction

  function automatic logic [15:0] m_head();
    return (mq.size() != 0) ? mq[0] : 16'h0000;
  endfunction

  function automatic logic [15:0] m_level();
    return 16'(mlvl);
  endfunction

  task automatic m_push(logic e, int i);
    if (mq.size() == DEPTH) movf = 1'b1;
    else mq.push_back(16'h8000 | (e ? 16'h0100 : 16'h0000) | 16'(i));
  endtask

  // a settled level change yields one event per changed input, lowest index first
  task automatic m_apply(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i] != mlvl[i]) m_push(v[i], i);
    mlvl = v;
  endtask

  task automatic m_pop();
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic m_reset();
    mq.delete();
    movf = 1'b0;
    mlvl = '0;
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(logic [N-1:0] v);
    btn_in = v;
    m_apply(v);
    step(SETTLE);
  endtask

  task automatic rd(int off, logic [15:0] exp, string nm);
    en = 1'b1; we = 1'b0; addr = 16'(off);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wr(int off, logic [15:0] d);
    en = 1'b1; we = 1'b1; addr = 16'(off); data = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]  d;
    logic [N-1:0] g;
    int           len;
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; data = '0; btn_in = '0;
    m_reset();
    step(3);
    rst = 1'b0;
    chk("reset_q", q, 16'h0000);
    chk("reset_event_pending", 16'(event_pending), 16'h0000);
    rd(0, 16'h0200, "reset_status");

    // single press: count rises exactly 7 edges after the change
    btn_in[3] = 1'b1;
    m_apply(8'h08);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("latency_edge6_pending", 16'(event_pending), 16'h0000);
    @(negedge clk);
    chk("latency_edge7_pending", 16'(event_pending), 16'h0001);
    step(SETTLE);
    rd(2, 16'h8103, "press_head");
    rd(1, 16'h0008, "press_level");

    // release then flush
    set_btn(8'h00);
    rd(2, m_head(), "release_head_still_press");
    wr(4, 16'h0001);
    mq.delete();
    rd(0, 16'h0200, "flush1_status");

    // short glitch produces nothing
    btn_in[3] = 1'b1;
    step(3);
    btn_in[3] = 1'b0;
    step(SETTLE);
    rd(1, 16'h0000, "glitch_level");
    rd(0, 16'h0200, "glitch_status");

    // simultaneous rise of inputs 1 and 5
    set_btn(8'h22);
    rd(2, 16'h8101, "pair_head1");
    wr(3, 16'h0000); m_pop();
    rd(2, 16'h8105, "pair_head2");
    wr(3, 16'h0000); m_pop();
    rd(0, 16'h0200, "pair_status_empty");
    wr(3, 16'h0000); m_pop();
    rd(0, 16'h0200, "pop_empty_ignored");

    // nine events without pops -> full and overflow
    set_btn(8'hFF);
    set_btn(8'hFC);
    set_btn(8'hFD);
    rd(0, 16'h0508, "overflow_status");
    wr(0, 16'h0100); movf = 1'b0;
    rd(0, 16'h0408, "overflow_clear_status");

    // pop and push in the same cycle while full
    btn_in = 8'h7D;
    m_pop();
    m_apply(8'h7D);
    repeat (6) @(posedge clk);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 16'd3;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
    step(SETTLE);
    rd(0, 16'h0408, "pushpop_status");
    rd(2, m_head(), "pushpop_head");

    wr(4, 16'h0001);
    mq.delete();
    chk("flush_event_pending", 16'(event_pending), 16'h0000);
    rd(0, 16'h0200, "flush2_status");

    // unmapped offsets
    rd(5, 16'h0000, "unmapped5");
    rd(6, 16'h0000, "unmapped6");
    rd(7, 16'h0000, "unmapped7");
    wr(6, 16'hFFFF);
    wr(5, 16'hFFFF);
    rd(0, m_status(), "unmapped_write_status");
    rd(1, m_level(), "unmapped_write_level");

    // randomized operation against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: set_btn(N'($urandom));
        2: begin
          g   = N'($urandom_range(1, 255));
          len = $urandom_range(1, D - 1);
          btn_in = btn_in ^ g;
          step(len);
          btn_in = btn_in ^ g;
          step(SETTLE);
        end
        3: begin wr(3, 16'($urandom)); m_pop(); end
        4: begin d = 16'($urandom); wr(0, d); if (d[8]) movf = 1'b0; end
        default: begin d = 16'($urandom); wr(4, d); if (d[0]) mq.delete(); end
      endcase
      rd(0, m_status(), "rnd_status");
      rd(2, m_head(), "rnd_head");
      rd(1, m_level(), "rnd_level");
      chk("rnd_event_pending", 16'(event_pending), 16'(mq.size() != 0));
    end

    // reset with events queued discards them
    wr(4, 16'h0001);
    mq.delete();
    set_btn(~mlvl);
    rd(0, m_status(), "pre_reset_status");
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    m_reset();
    chk("midreset_event_pending", 16'(event_pending), 16'h0000);
    rd(0, 16'h0200, "midreset_status");
    rd(1, 16'h0000, "midreset_level");

    step(2);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
